wishbone_mem_arbiter: RTL and testbench
=======================================

Name: wishbone_mem_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter that shares the memory interconnect's single master port between a host-interface master (m0) and a DMA master (m1).
- Round-robin grant is held for the whole bus cycle (cyc), with one idle cycle between grants.
- A per-transfer watchdog force-terminates stalled strobes so a missing slave ack cannot hang either master.

Parameters:
- TIMEOUT_CYCLES, 256, number of consecutive granted stb-without-ack cycles before a forced ack; 0 disables the watchdog.
- TO_WIDTH, 16, width of the watchdog counter; TIMEOUT_CYCLES must be < 2^TO_WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- m0_we_i, m0_cyc_i, m0_stb_i  in  1 each  master 0 write enable, cycle, strobe
- m0_sel_i  in  4  master 0 byte selects
- m0_adr_i  in  32  master 0 address
- m0_dat_i  in  32  master 0 write data
- m0_dat_o  out  32  master 0 read data
- m0_ack_o  out  1  master 0 ack
- m0_int_o  out  1  master 0 interrupt
- m1_*  same set and widths as m0_*, for master 1
- s_we_o, s_cyc_o, s_stb_o  out  1 each  to interconnect
- s_sel_o  out  4  to interconnect
- s_adr_o  out  32  to interconnect
- s_dat_o  out  32  to interconnect
- s_dat_i  in  32  read data from interconnect
- s_ack_i  in  1  ack from interconnect
- s_int_i  in  1  interrupt from interconnect
- timeout_o  out  1  sticky watchdog-fired flag

Behaviour:
- Clocking and reset: single clock domain, sync active-high reset.
  - On reset: state=IDLE, last_grant=1 (so m0 wins the first tie), watchdog count=0, timeout_o=0.
  - All s_*_o and m*_ack_o/m*_dat_o are 0 while in reset and IDLE.
- State machine, registered:
  - IDLE: both cyc high -> grant the master not equal to last_grant. Only one cyc high -> grant that master. Neither -> stay IDLE.
  - GRANT0: m0_cyc_i low -> IDLE, last_grant<=0. Otherwise stay.
  - GRANT1: m1_cyc_i low -> IDLE, last_grant<=1. Otherwise stay.
- Latency:
  - First s_cyc_o is 1 cycle after the requesting cyc rises from IDLE.
  - Handover always passes through exactly one IDLE cycle; there is no direct GRANT0<->GRANT1 transition.
- Datapath, combinational from state:
  - In GRANTn, s_we/cyc/stb/sel/adr/dat_o = mn_* inputs.
  - mn_dat_o = s_dat_i and mn_ack_o = s_ack_i (OR forced ack).
  - Non-granted master sees ack=0, dat=0. It simply waits with stb held; this is legal Wishbone.
- Interrupt: s_int_i is broadcast to m0_int_o and m1_int_o regardless of grant.
- Watchdog, active when TIMEOUT_CYCLES>0:
  - Counts cycles in GRANTn with s_stb_o=1 and s_ack_i=0; cleared on any ack, stb low, or IDLE.
  - When count==TIMEOUT_CYCLES-1 and still no ack, the next cycle drives mn_ack_o=1 and mn_dat_o=32'hFFFF_FFFF for exactly one cycle.
  - In that same cycle s_stb_o is forced 0 so the slave does not see the orphan strobe. timeout_o<=1, count<=0.
  - timeout_o clears only on rst.
- Simultaneous events:
  - s_ack_i arriving in the forced-ack cycle is ignored; exactly one ack reaches the master.
  - Granted master dropping cyc in the same cycle as a new request from the other master -> IDLE, then grant the other master.
- Reset mid-transfer: next edge returns to IDLE with all outputs 0; any pending slave ack afterward is dropped.
- Back-to-back strobes within one cyc stay on the same grant; the other master cannot preempt.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x10 with m1 idle -> s_cyc_o rises 1 cycle after m0_cyc_i; s_dat_o=0xDEADBEEF; m0_ack_o mirrors s_ack_i; m1_ack_o stays 0.
- Tie after reset: m0_cyc_i and m1_cyc_i rise together -> GRANT0 first. When m0 drops cyc, one IDLE cycle follows, then GRANT1 with s_adr_o=m1_adr_i.
- Fairness: both masters hold cyc continuously with 1-transfer bursts, 8 cycles each -> grants alternate 0,1,0,1,0,1,0,1; no master is granted twice in a row while the other waits.
- Watchdog: TIMEOUT_CYCLES=4, slave never acks m1 read -> forced m1_ack_o pulse in the 5th stb cycle with m1_dat_o=0xFFFFFFFF; s_stb_o=0 that cycle; timeout_o=1 and stays 1 until rst.
- Reset mid-cycle: assert rst while GRANT1 and stb high -> next cycle all s_*_o=0, timeout_o=0; after release, m0 wins the tie.
- Interrupt: pulse s_int_i during GRANT0 -> m0_int_o and m1_int_o both mirror it combinationally.

Source files
------------

// File: rtl/wishbone_mem_arbiter.sv
// Two-master to one-slave Wishbone arbiter.
// Round-robin grant held for a whole bus cycle, one IDLE cycle between grants,
// and a per-transfer watchdog that force-acks strobes the slave never answers.
module wishbone_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = 16
) (
  input  logic        clk,
  input  logic        rst,
  // master 0 (host interface)
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_int_o,
  // master 1 (DMA)
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_int_o,
  // shared slave port
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_int_i,
  // sticky watchdog flag
  output logic        timeout_o
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  // Watchdog is compiled in only for a non-zero timeout.
  localparam bit WD_EN = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(WD_EN ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);

  logic [1:0]          state_q, state_d;
  logic                last_q, last_d;
  logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
  logic                force_q, force_d;
  logic                timeout_q, timeout_d;

  logic gnt0;
  logic gnt1;

  // Grants are qualified by reset so the slave port is quiet throughout reset.
  assign gnt0 = !rst && (state_q == ST_GRANT0);
  assign gnt1 = !rst && (state_q == ST_GRANT1);

  // Interrupt is broadcast to both masters independent of grant.
  assign m0_int_o  = s_int_i;
  assign m1_int_o  = s_int_i;
  assign timeout_o = timeout_q;

  // State, round-robin pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      wd_cnt_q  <= '0;
      force_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_cnt_q  <= wd_cnt_d;
      force_q   <= force_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: grant held for the whole cyc, handover always via IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ST_GRANT0 : ST_GRANT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GRANT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!m0_cyc_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end
      ST_GRANT1: begin
        if (!m1_cyc_i) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath mux; during a forced-ack cycle the strobe is hidden from the slave
  // and the master receives an all-ones read word in place of the slave data.
  always_comb begin
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_sel_o  = SW'(0);
    s_adr_o  = DW'(0);
    s_dat_o  = DW'(0);
    m0_ack_o = 1'b0;
    m0_dat_o = DW'(0);
    m1_ack_o = 1'b0;
    m1_dat_o = DW'(0);
    if (gnt0) begin
      s_we_o   = m0_we_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i && !force_q;
      s_sel_o  = m0_sel_i;
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      m0_ack_o = force_q || s_ack_i;
      m0_dat_o = force_q ? {DW{1'b1}} : s_dat_i;
    end else if (gnt1) begin
      s_we_o   = m1_we_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i && !force_q;
      s_sel_o  = m1_sel_i;
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      m1_ack_o = force_q || s_ack_i;
      m1_dat_o = force_q ? {DW{1'b1}} : s_dat_i;
    end
  end

  // Watchdog: count unanswered granted strobes, fire a one-cycle forced ack.
  always_comb begin
    wd_cnt_d  = '0;
    force_d   = 1'b0;
    timeout_d = timeout_q;
    if (WD_EN && s_cyc_o && s_stb_o && !s_ack_i) begin
      if (wd_cnt_q == TO_LAST) begin
        force_d   = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + TO_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_wishbone_mem_arbiter.sv
// Self-checking bench for wishbone_mem_arbiter (watchdog shortened to 4 cycles).
module tb_wishbone_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_we_i, m0_cyc_i, m0_stb_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_int_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_int_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i, s_int_i;
  logic        timeout_o;

  logic        auto_ack;
  logic        man_ack;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] rdat;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Slave model: either an immediate acker or a manually driven ack.
  assign s_ack_i = auto_ack ? (s_cyc_o & s_stb_o) : man_ack;

  wishbone_mem_arbiter #(.TIMEOUT_CYCLES(4), .TO_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_int_o(m0_int_o),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_int_o(m1_int_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_int_i(s_int_i), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_m0();
    m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m0_sel_i = 4'h0; m0_adr_i = 32'h0; m0_dat_i = 32'h0;
  endtask

  task automatic idle_m1();
    m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    m1_sel_i = 4'h0; m1_adr_i = 32'h0; m1_dat_i = 32'h0;
  endtask

  task automatic req_m0(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m0_we_i = we; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m0_sel_i = 4'hF; m0_adr_i = adr; m0_dat_i = dat;
  endtask

  task automatic req_m1(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    m1_we_i = we; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    m1_sel_i = 4'hF; m1_adr_i = adr; m1_dat_i = dat;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_m0(); idle_m1();
    man_ack = 1'b0; auto_ack = 1'b0; s_dat_i = 32'h0; s_int_i = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_m1(); man_ack = 1'b1; auto_ack = 1'b0; s_dat_i = 32'h1234_5678; s_int_i = 1'b0;
    req_m0(1'b1, 32'h44, 32'h7777_7777);
    step(); step();
    sample();
    n_checks++;
    if ({s_we_o, s_cyc_o, s_stb_o} !== 3'b000) begin
      n_fail++; $display("FAIL reset_s_ctrl: got %b expected 000", {s_we_o, s_cyc_o, s_stb_o});
    end
    n_checks++;
    if ({s_sel_o, s_adr_o, s_dat_o} !== 68'h0) begin
      n_fail++; $display("FAIL reset_s_data: got sel=%h adr=%h dat=%h expected 0", s_sel_o, s_adr_o, s_dat_o);
    end
    n_checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_acks: got %b expected 00", {m0_ack_o, m1_ack_o});
    end
    n_checks++;
    if ({m0_dat_o, m1_dat_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_mdat: got %h %h expected 0", m0_dat_o, m1_dat_o);
    end
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    exp_t e;
    step();
    req_m0(1'b1, 32'h10, 32'hDEAD_BEEF);
    exp_q.push_back('{adr: 32'h10, dat: 32'hDEAD_BEEF, we: 1'b1, sel: 4'hF, rdat: 32'h0BAD_F00D});
    sample();
    n_checks++;
    if (s_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL single_idle_latency: s_cyc_o got %b expected 0", s_cyc_o);
    end
    step();
    man_ack = 1'b1; s_dat_i = 32'h0BAD_F00D;
    sample();
    n_checks++;
    if ({s_cyc_o, s_stb_o} !== 2'b11) begin
      n_fail++; $display("FAIL single_grant: cyc/stb got %b expected 11", {s_cyc_o, s_stb_o});
    end
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL single_scoreboard: queue empty expected 1 entry");
    end else begin
      e = exp_q.pop_front();
      n_checks++;
      if ({s_adr_o, s_dat_o, s_we_o, s_sel_o} !== {e.adr, e.dat, e.we, e.sel}) begin
        n_fail++; $display("FAIL single_payload: got adr=%h dat=%h we=%b sel=%h expected adr=%h dat=%h we=%b sel=%h",
                           s_adr_o, s_dat_o, s_we_o, s_sel_o, e.adr, e.dat, e.we, e.sel);
      end
      n_checks++;
      if ({m0_ack_o, m0_dat_o} !== {1'b1, e.rdat}) begin
        n_fail++; $display("FAIL single_m0_resp: got ack=%b dat=%h expected ack=1 dat=%h", m0_ack_o, m0_dat_o, e.rdat);
      end
    end
    n_checks++;
    if ({m1_ack_o, m1_dat_o} !== 33'h0) begin
      n_fail++; $display("FAIL single_m1_quiet: got ack=%b dat=%h expected 0", m1_ack_o, m1_dat_o);
    end
    step();
    idle_m0(); man_ack = 1'b0;
    sample();
    n_checks++;
    if (m0_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL single_ack_mirror: got %b expected 0", m0_ack_o);
    end
    step(); step();
  endtask

  task automatic test_tie();
    exp_t e;
    do_reset();
    req_m0(1'b0, 32'h100, 32'h0);
    req_m1(1'b0, 32'h200, 32'h0);
    exp_q.push_back('{adr: 32'h100, dat: 32'h0, we: 1'b0, sel: 4'hF, rdat: 32'h1111_1111});
    exp_q.push_back('{adr: 32'h200, dat: 32'h0, we: 1'b0, sel: 4'hF, rdat: 32'hCAFE_F00D});
    sample();
    step();
    man_ack = 1'b1; s_dat_i = 32'h1111_1111;
    sample();
    e = exp_q.pop_front();
    n_checks++;
    if (s_adr_o !== e.adr) begin
      n_fail++; $display("FAIL tie_first_grant: s_adr_o got %h expected %h", s_adr_o, e.adr);
    end
    n_checks++;
    if ({m0_ack_o, m1_ack_o, m0_dat_o} !== {2'b10, e.rdat}) begin
      n_fail++; $display("FAIL tie_m0_resp: got acks=%b%b dat=%h expected 10 %h", m0_ack_o, m1_ack_o, m0_dat_o, e.rdat);
    end
    step();
    idle_m0(); man_ack = 1'b0;
    sample();
    step();
    sample();
    n_checks++;
    if ({s_cyc_o, s_stb_o} !== 2'b00) begin
      n_fail++; $display("FAIL tie_idle_gap: cyc/stb got %b expected 00", {s_cyc_o, s_stb_o});
    end
    step();
    man_ack = 1'b1; s_dat_i = 32'hCAFE_F00D;
    sample();
    e = exp_q.pop_front();
    n_checks++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, e.adr}) begin
      n_fail++; $display("FAIL tie_second_grant: got cyc=%b adr=%h expected 1 %h", s_cyc_o, s_adr_o, e.adr);
    end
    n_checks++;
    if ({m1_ack_o, m0_ack_o, m1_dat_o} !== {2'b10, e.rdat}) begin
      n_fail++; $display("FAIL tie_m1_resp: got m1ack=%b m0ack=%b dat=%h expected 1 0 %h", m1_ack_o, m0_ack_o, m1_dat_o, e.rdat);
    end
    step();
    idle_m1(); man_ack = 1'b0;
    step(); step();
  endtask

  task automatic test_fairness();
    int  grants;
    int  cycles;
    int  obs;
    int  exp_m;
    bit  drop0, drop1, rise0, rise1;
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 8; i++) grant_q.push_back(i % 2);
    grants = 0; cycles = 0;
    drop0 = 0; drop1 = 0; rise0 = 0; rise1 = 0;
    req_m0(1'b1, 32'h1000, 32'hA0A0_0000);
    req_m1(1'b1, 32'h2000, 32'hB1B1_0000);
    while (grants < 8 && cycles < 200) begin
      sample();
      if (m0_ack_o && m1_ack_o) begin
        n_checks++; n_fail++; $display("FAIL fair_double_ack: both acks high at cycle %0d", cycles);
      end else if (m0_ack_o || m1_ack_o) begin
        obs = m0_ack_o ? 0 : 1;
        exp_m = grant_q.pop_front();
        n_checks++;
        if (obs !== exp_m) begin
          n_fail++; $display("FAIL fair_order: grant %0d got master %0d expected %0d", grants, obs, exp_m);
        end
        grants++;
        if (m0_ack_o) drop0 = 1; else drop1 = 1;
      end
      step();
      cycles++;
      if (drop0) begin
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; drop0 = 0; rise0 = 1;
      end else if (rise0) begin
        req_m0(1'b1, 32'h1000 + 32'(grants), 32'hA0A0_0000 + 32'(grants)); rise0 = 0;
      end
      if (drop1) begin
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; drop1 = 0; rise1 = 1;
      end else if (rise1) begin
        req_m1(1'b1, 32'h2000 + 32'(grants), 32'hB1B1_0000 + 32'(grants)); rise1 = 0;
      end
    end
    if (grants < 8) begin
      n_checks++; n_fail++; $display("FAIL fair_timeout: got %0d grants expected 8", grants);
    end
    grant_q.delete();
    auto_ack = 1'b0;
    idle_m0(); idle_m1();
    step(); step(); step();
  endtask

  task automatic test_watchdog();
    exp_t e;
    step();
    req_m1(1'b0, 32'h300, 32'h0);
    exp_q.push_back('{adr: 32'h300, dat: 32'h0, we: 1'b0, sel: 4'hF, rdat: 32'hFFFF_FFFF});
    sample();
    for (int k = 1; k <= 4; k++) begin
      step();
      sample();
      n_checks++;
      if ({m1_ack_o, s_stb_o, timeout_o} !== 3'b010) begin
        n_fail++; $display("FAIL wd_wait_%0d: ack/stb/timeout got %b expected 010", k, {m1_ack_o, s_stb_o, timeout_o});
      end
    end
    step();
    man_ack = 1'b1; s_dat_i = 32'h1234_5678;
    sample();
    e = exp_q.pop_front();
    n_checks++;
    if ({m1_ack_o, m1_dat_o} !== {1'b1, e.rdat}) begin
      n_fail++; $display("FAIL wd_forced_ack: got ack=%b dat=%h expected 1 %h", m1_ack_o, m1_dat_o, e.rdat);
    end
    n_checks++;
    if ({s_stb_o, s_adr_o} !== {1'b0, e.adr}) begin
      n_fail++; $display("FAIL wd_stb_hidden: got stb=%b adr=%h expected 0 %h", s_stb_o, s_adr_o, e.adr);
    end
    n_checks++;
    if (timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL wd_timeout_set: got %b expected 1", timeout_o);
    end
    step();
    idle_m1(); man_ack = 1'b0;
    sample();
    n_checks++;
    if (m1_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL wd_single_ack: got %b expected 0", m1_ack_o);
    end
    step(); step(); step();
    sample();
    n_checks++;
    if (timeout_o !== 1'b1) begin
      n_fail++; $display("FAIL wd_sticky: got %b expected 1", timeout_o);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    step();
    req_m1(1'b1, 32'h400, 32'h55AA_55AA);
    sample();
    step();
    sample();
    n_checks++;
    if ({s_stb_o, s_adr_o} !== {1'b1, 32'h400}) begin
      n_fail++; $display("FAIL rmid_granted: got stb=%b adr=%h expected 1 00000400", s_stb_o, s_adr_o);
    end
    step();
    rst = 1'b1; man_ack = 1'b1;
    sample();
    step();
    rst = 1'b0;
    req_m0(1'b0, 32'h500, 32'h0);
    exp_q.push_back('{adr: 32'h500, dat: 32'h0, we: 1'b0, sel: 4'hF, rdat: 32'h0});
    sample();
    n_checks++;
    if ({s_we_o, s_cyc_o, s_stb_o, s_sel_o, s_adr_o, s_dat_o} !== 71'h0) begin
      n_fail++; $display("FAIL rmid_outputs: got we=%b cyc=%b stb=%b sel=%h adr=%h dat=%h expected 0",
                         s_we_o, s_cyc_o, s_stb_o, s_sel_o, s_adr_o, s_dat_o);
    end
    n_checks++;
    if ({timeout_o, m0_ack_o, m1_ack_o} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_flags: timeout/acks got %b expected 000", {timeout_o, m0_ack_o, m1_ack_o});
    end
    step();
    man_ack = 1'b0;
    sample();
    e = exp_q.pop_front();
    n_checks++;
    if ({s_cyc_o, s_adr_o} !== {1'b1, e.adr}) begin
      n_fail++; $display("FAIL rmid_tie_m0: got cyc=%b adr=%h expected 1 %h", s_cyc_o, s_adr_o, e.adr);
    end
    idle_m0(); idle_m1();
    step(); step(); step();
  endtask

  task automatic test_interrupt();
    step();
    req_m0(1'b0, 32'h600, 32'h0);
    sample();
    step();
    s_int_i = 1'b1;
    sample();
    n_checks++;
    if ({s_cyc_o, m0_int_o, m1_int_o} !== 3'b111) begin
      n_fail++; $display("FAIL int_high: cyc/int0/int1 got %b expected 111", {s_cyc_o, m0_int_o, m1_int_o});
    end
    step();
    s_int_i = 1'b0;
    sample();
    n_checks++;
    if ({m0_int_o, m1_int_o} !== 2'b00) begin
      n_fail++; $display("FAIL int_low: got %b expected 00", {m0_int_o, m1_int_o});
    end
    step();
    idle_m0();
    step(); step();
  endtask

  initial begin
    rst = 1'b1;
    idle_m0(); idle_m1();
    man_ack = 1'b0; auto_ack = 1'b0; s_dat_i = 32'h0; s_int_i = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_watchdog();
    test_reset_mid();
    test_interrupt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "bench time limit expired");
  end

endmodule
